// File: rtl/mp_reg_file_pkg.sv
// Shared constants for the multi-port register file: FSM state codes and default sizing.
package mp_reg_file_pkg;

    localparam int unsigned AddrLenDef    = 5;
    localparam int unsigned DataLenDef    = 32;
    localparam int unsigned NumRdPortsDef = 2;

    localparam logic [0:0] StInit = 1'b0;
    localparam logic [0:0] StIdle = 1'b1;

endpackage

// File: rtl/mp_reg_file_rd_port.sv
// One read port: registered read data with write-first bypass and zero return during init.
module mp_reg_file_rd_port
    import mp_reg_file_pkg::*;
#(
    parameter int unsigned AddrLen = AddrLenDef,
    parameter int unsigned DataLen = DataLenDef
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               rd_i,
    input  logic [AddrLen-1:0] rd_addr_i,
    input  logic [DataLen-1:0] mem_data_i,
    input  logic               init_i,
    input  logic               wr_en_i,
    input  logic [AddrLen-1:0] wr_addr_i,
    input  logic [DataLen-1:0] wr_data_i,
    output logic [DataLen-1:0] data_o,
    output logic               valid_o
);

    logic [DataLen-1:0] data_q, data_d;
    logic               valid_q;

    always_comb begin
        data_d = data_q;
        if (rd_i) begin
            if (init_i) begin
                data_d = '0;
            end else if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
                data_d = wr_data_i;
            end else begin
                data_d = mem_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= rd_i;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/mp_reg_file.sv
// Multi-read-port register file with sequential zeroing after reset or on a clear request.
module mp_reg_file
    import mp_reg_file_pkg::*;
#(
    parameter int unsigned addrLen    = AddrLenDef,
    parameter int unsigned dataLen    = DataLenDef,
    parameter int unsigned numRdPorts = NumRdPortsDef
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wrt,
    input  logic [addrLen-1:0]              wrtAddr,
    input  logic [dataLen-1:0]              dataIn,
    input  logic                            clr,
    input  logic [numRdPorts-1:0]           rd,
    input  logic [numRdPorts*addrLen-1:0]   rdAddr,
    output logic [numRdPorts*dataLen-1:0]   dataOut,
    output logic [numRdPorts-1:0]           rdValid,
    output logic                            ready
);

    localparam int unsigned Depth = 2 ** addrLen;

    logic [0:0]         state_q, state_d;
    logic [addrLen-1:0] init_cnt_q, init_cnt_d;
    logic [dataLen-1:0] mem_q [Depth];

    logic               in_init;
    logic               wr_accept;
    logic               mem_we;
    logic [addrLen-1:0] mem_waddr;
    logic [dataLen-1:0] mem_wdata;

    assign in_init   = (state_q == StInit);
    assign wr_accept = !in_init && wrt && !clr;
    assign ready     = (state_q == StIdle);

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (clr) begin
            state_d    = StInit;
            init_cnt_d = '0;
        end else if (in_init) begin
            init_cnt_d = init_cnt_q + addrLen'(1);
            if (&init_cnt_q) begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Single write port shared by the init sweep and normal writes; clr suppresses both.
    always_comb begin
        mem_we    = (in_init && !clr) || wr_accept;
        mem_waddr = in_init ? init_cnt_q : wrtAddr;
        mem_wdata = in_init ? '0 : dataIn;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar p = 0; p < numRdPorts; p++) begin : g_rd
        mp_reg_file_rd_port #(
            .AddrLen (addrLen),
            .DataLen (dataLen)
        ) u_rd_port (
            .clk_i      (clk),
            .rst_i      (reset),
            .rd_i       (rd[p]),
            .rd_addr_i  (rdAddr[p*addrLen +: addrLen]),
            .mem_data_i (mem_q[rdAddr[p*addrLen +: addrLen]]),
            .init_i     (in_init),
            .wr_en_i    (wr_accept),
            .wr_addr_i  (wrtAddr),
            .wr_data_i  (dataIn),
            .data_o     (dataOut[p*dataLen +: dataLen]),
            .valid_o    (rdValid[p])
        );
    end

endmodule

// File: tb/tb_mp_reg_file.sv
// Directed self-checking bench for mp_reg_file with two read ports.
module tb_mp_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        wrt;
    logic [4:0]  wrtAddr;
    logic [31:0] dataIn;
    logic        clr;
    logic [1:0]  rd;
    logic [9:0]  rdAddr;
    logic [63:0] dataOut;
    logic [1:0]  rdValid;
    logic        ready;

    int checks = 0;
    int errors = 0;

    mp_reg_file #(
        .addrLen    (5),
        .dataLen    (32),
        .numRdPorts (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wrt     (wrt),
        .wrtAddr (wrtAddr),
        .dataIn  (dataIn),
        .clr     (clr),
        .rd      (rd),
        .rdAddr  (rdAddr),
        .dataOut (dataOut),
        .rdValid (rdValid),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects 32 cycles of ready low followed by ready high.
    task automatic sweep_check(input string tag);
        for (int i = 0; i < 32; i++) begin
            check({tag, "_ready_low"}, {31'd0, ready}, 32'd0);
            tick();
        end
        check({tag, "_ready_high"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        reset   = 1'b1;
        wrt     = 1'b0;
        wrtAddr = '0;
        dataIn  = '0;
        clr     = 1'b0;
        rd      = '0;
        rdAddr  = '0;
        repeat (3) tick();
        check("rst_dout0", dataOut[31:0], 32'd0);
        check("rst_dout1", dataOut[63:32], 32'd0);
        check("rst_valid", {30'd0, rdValid}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);

        reset = 1'b0;
        sweep_check("init");

        // All entries zeroed after the sweep; port 1 walks the other way.
        for (int a = 0; a < 32; a++) begin
            rd     = 2'b11;
            rdAddr = {5'(31 - a), 5'(a)};
            tick();
            check("zero_p0", dataOut[31:0], 32'd0);
            check("zero_p1", dataOut[63:32], 32'd0);
            check("zero_valid", {30'd0, rdValid}, 32'd3);
        end
        rd = 2'b00;
        tick();
        check("idle_valid", {30'd0, rdValid}, 32'd0);

        wrt     = 1'b1;
        wrtAddr = 5'd3;
        dataIn  = 32'hDEADBEEF;
        tick();
        wrt    = 1'b0;
        rd     = 2'b01;
        rdAddr = {5'd0, 5'd3};
        tick();
        check("rd3_p0", dataOut[31:0], 32'hDEADBEEF);
        check("rd3_valid", {30'd0, rdValid}, 32'd1);

        wrt     = 1'b1;
        wrtAddr = 5'd7;
        dataIn  = 32'h00001234;
        rd      = 2'b10;
        rdAddr  = {5'd7, 5'd0};
        tick();
        wrt = 1'b0;
        check("bypass_p1", dataOut[63:32], 32'h00001234);
        check("bypass_valid", {30'd0, rdValid}, 32'd2);
        check("hold_p0", dataOut[31:0], 32'hDEADBEEF);

        rd     = 2'b11;
        rdAddr = {5'd7, 5'd3};
        tick();
        check("dual_p0", dataOut[31:0], 32'hDEADBEEF);
        check("dual_p1", dataOut[63:32], 32'h00001234);
        check("dual_valid", {30'd0, rdValid}, 32'd3);

        // clr wins over a same-cycle write.
        rd      = 2'b00;
        clr     = 1'b1;
        wrt     = 1'b1;
        wrtAddr = 5'd5;
        dataIn  = 32'hFFFFFFFF;
        tick();
        clr = 1'b0;
        wrt = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("clr_ready_low", {31'd0, ready}, 32'd0);
            if (i > 0) begin
                check("init_rd_p0", dataOut[31:0], 32'd0);
                check("init_rd_valid", {31'd0, rdValid[0]}, 32'd1);
            end
            rd     = 2'b01;
            rdAddr = {5'd0, 5'd3};
            tick();
        end
        check("clr_ready_high", {31'd0, ready}, 32'd1);
        for (int a = 0; a < 32; a++) begin
            rd     = 2'b01;
            rdAddr = {5'd0, 5'(a)};
            tick();
            check("clr_zero_p0", dataOut[31:0], 32'd0);
        end

        wrt     = 1'b1;
        wrtAddr = 5'd9;
        dataIn  = 32'hA5A5A5A5;
        rd      = 2'b00;
        tick();
        wrt    = 1'b0;
        rd     = 2'b11;
        rdAddr = {5'd9, 5'd9};
        tick();
        check("a5_p0", dataOut[31:0], 32'hA5A5A5A5);
        check("a5_p1", dataOut[63:32], 32'hA5A5A5A5);

        // Start a sweep, then reset once initCnt has reached 10.
        rd  = 2'b00;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (10) tick();
        check("pre_rst_p0", dataOut[31:0], 32'hA5A5A5A5);
        reset = 1'b1;
        #1;
        check("mid_rst_p0", dataOut[31:0], 32'd0);
        check("mid_rst_p1", dataOut[63:32], 32'd0);
        check("mid_rst_valid", {30'd0, rdValid}, 32'd0);
        check("mid_rst_ready", {31'd0, ready}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        sweep_check("rst_sweep");
        rd     = 2'b11;
        rdAddr = {5'd9, 5'd31};
        tick();
        check("final_p0", dataOut[31:0], 32'd0);
        check("final_p1", dataOut[63:32], 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
